// File: rtl/input_conditioner_pkg.sv
// rtl/input_conditioner_pkg.sv - shared constants and counter sizing helper for input_conditioner
// Contents:
//   DEFAULT_DEBOUNCE_CYCLES  10 ms at 50 MHz
//   SIM_DEBOUNCE_CYCLES      short period for simulation
//   CLK_HZ                   system clock frequency
//   cnt_width()              minimum counter width W with 2^W > debounce_cycles
package input_cond_pkg;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;
    localparam int SIM_DEBOUNCE_CYCLES     = 8;
    localparam int CLK_HZ                  = 50000000;

    function automatic int cnt_width(input int debounce_cycles);
        int w;
        w = 1;
        while ((64'd1 << w) <= 64'(debounce_cycles)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/input_conditioner_if.sv
// rtl/input_conditioner_if.sv - pin and conditioned-output bundle for input_conditioner
// Signals:
//   key_n_raw, sw_raw, edge_clear                 driven by master (board/test side)
//   pushbuttons_export, switches_export,
//   press_pulse, release_pulse, edge_capture      driven by slave (conditioner)
interface input_conditioner_if #(
    parameter int N_KEYS = 4,
    parameter int N_SW   = 10
);
    logic [N_KEYS-1:0] key_n_raw;
    logic [N_SW-1:0]   sw_raw;
    logic [N_KEYS-1:0] edge_clear;
    logic [N_KEYS-1:0] pushbuttons_export;
    logic [N_SW-1:0]   switches_export;
    logic [N_KEYS-1:0] press_pulse;
    logic [N_KEYS-1:0] release_pulse;
    logic [N_KEYS-1:0] edge_capture;

    modport master (
        output key_n_raw, sw_raw, edge_clear,
        input  pushbuttons_export, switches_export, press_pulse, release_pulse, edge_capture
    );

    modport slave (
        input  key_n_raw, sw_raw, edge_clear,
        output pushbuttons_export, switches_export, press_pulse, release_pulse, edge_capture
    );
endinterface

// File: rtl/input_conditioner_debounce.sv
// rtl/input_conditioner_debounce.sv - one channel: two-flop synchroniser, counter debouncer, rise/fall pulses
// Ports:
//   clk_i    system clock
//   rst_i    synchronous reset, active-high
//   raw_i    asynchronous active-high input
//   level_o  registered debounced level
//   rise_o   one-cycle pulse the cycle after level_o goes 0->1
//   fall_o   one-cycle pulse the cycle after level_o goes 1->0
module debounce_channel #(
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int CNT_W           = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1_q, s2_q;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_dly_q;
    logic             rise_q, fall_q;

    // Any sample matching the accepted level wipes the count, so a bounce
    // back to the old level forfeits all progress.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (s2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = s2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            stable_q    <= 1'b0;
            cnt_q       <= '0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
            rise_q      <= 1'b0;
            fall_q      <= 1'b0;
        end else begin
            s1_q        <= raw_i;
            s2_q        <= s1_q;
            stable_q    <= stable_d;
            cnt_q       <= cnt_d;
            // Output level is a registered copy of the accepted level; the
            // pulses follow it by one more cycle.
            level_q     <= stable_q;
            level_dly_q <= level_q;
            rise_q      <= level_q & ~level_dly_q;
            fall_q      <= ~level_q & level_dly_q;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;
endmodule

// File: rtl/input_conditioner.sv
// rtl/input_conditioner.sv - debounces DE1-SoC keys and switches, adds press/release pulses and sticky edge capture
// Ports:
//   clk_clk      system clock (50 MHz)
//   reset_reset  synchronous reset, active-high
//   io           input_conditioner_if.slave: raw pins and edge_clear in,
//                debounced levels, pulses and edge_capture out
module input_conditioner
    import input_cond_pkg::*;
#(
    parameter int N_KEYS          = 4,
    parameter int N_SW            = 10,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = 20
) (
    input logic                 clk_clk,
    input logic                 reset_reset,
    input_conditioner_if.slave  io
);
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_cycles
        $error("DEBOUNCE_CYCLES must be at least 2");
    end
    if ((64'd1 << CNT_W) <= 64'(DEBOUNCE_CYCLES)) begin : g_bad_width
        $error("CNT_W too narrow for DEBOUNCE_CYCLES");
    end

    logic [N_KEYS-1:0] key_level, key_rise, key_fall;
    logic [N_SW-1:0]   sw_level;
    logic [N_KEYS-1:0] edge_capture_q, edge_capture_d;

    for (genvar i = 0; i < N_KEYS; i++) begin : g_key
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_chan (
            .clk_i   (clk_clk),
            .rst_i   (reset_reset),
            .raw_i   (~io.key_n_raw[i]),
            .level_o (key_level[i]),
            .rise_o  (key_rise[i]),
            .fall_o  (key_fall[i])
        );
    end

    for (genvar i = 0; i < N_SW; i++) begin : g_sw
        logic sw_rise_unused, sw_fall_unused;
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_chan (
            .clk_i   (clk_clk),
            .rst_i   (reset_reset),
            .raw_i   (io.sw_raw[i]),
            .level_o (sw_level[i]),
            .rise_o  (sw_rise_unused),
            .fall_o  (sw_fall_unused)
        );
    end

    // Clear first, then set, so a press arriving with a clear still latches.
    always_comb begin
        edge_capture_d = (edge_capture_q & ~io.edge_clear) | key_rise;
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            edge_capture_q <= '0;
        end else begin
            edge_capture_q <= edge_capture_d;
        end
    end

    assign io.pushbuttons_export = key_level;
    assign io.switches_export    = sw_level;
    assign io.press_pulse        = key_rise;
    assign io.release_pulse      = key_fall;
    assign io.edge_capture       = edge_capture_q;
endmodule

// File: tb/tb_input_conditioner.sv
// tb/tb_input_conditioner.sv - directed self-checking bench for input_conditioner
module tb_input_conditioner;
    import input_cond_pkg::*;

    localparam int N_KEYS = 4;
    localparam int N_SW   = 10;
    localparam int DB     = SIM_DEBOUNCE_CYCLES;

    logic clk_clk;
    logic reset_reset;
    int   n_checks;
    int   n_passed;

    input_conditioner_if #(.N_KEYS(N_KEYS), .N_SW(N_SW)) io ();

    input_conditioner #(
        .N_KEYS          (N_KEYS),
        .N_SW            (N_SW),
        .DEBOUNCE_CYCLES (DB),
        .CNT_W           (4)
    ) dut (
        .clk_clk     (clk_clk),
        .reset_reset (reset_reset),
        .io          (io.slave)
    );

    initial clk_clk = 1'b0;
    always #5 clk_clk = ~clk_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_passed++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance one rising edge and land on the following falling edge.
    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk_clk);
            @(negedge clk_clk);
        end
    endtask

    logic seen_level, seen_press;

    initial begin
        n_checks = 0;
        n_passed = 0;
        reset_reset      = 1'b1;
        io.key_n_raw     = 4'b0000;
        io.sw_raw        = 10'h3FF;
        io.edge_clear    = 4'b0000;
        @(negedge clk_clk);

        // 1. Reset with keys pressed and switches high
        tick(3);
        check("rst_keys", 32'(io.pushbuttons_export), 32'h0);
        check("rst_sw", 32'(io.switches_export), 32'h0);
        check("rst_press", 32'(io.press_pulse), 32'h0);
        check("rst_release", 32'(io.release_pulse), 32'h0);
        check("rst_ecap", 32'(io.edge_capture), 32'h0);
        reset_reset = 1'b0;
        tick(DB + 2);                          // after edge 9
        check("pwrup_keys_e9", 32'(io.pushbuttons_export), 32'h0);
        check("pwrup_sw_e9", 32'(io.switches_export), 32'h0);
        tick(1);                               // after edge 10
        check("pwrup_keys_e10", 32'(io.pushbuttons_export), 32'hF);
        check("pwrup_sw_e10", 32'(io.switches_export), 32'h3FF);
        check("pwrup_press_e10", 32'(io.press_pulse), 32'h0);
        tick(1);
        check("pwrup_press_e11", 32'(io.press_pulse), 32'hF);
        tick(1);
        check("pwrup_press_e12", 32'(io.press_pulse), 32'h0);
        check("pwrup_ecap", 32'(io.edge_capture), 32'hF);
        io.edge_clear = 4'hF;
        tick(1);
        io.edge_clear = 4'h0;
        check("pwrup_ecap_clr", 32'(io.edge_capture), 32'h0);
        io.key_n_raw = 4'hF;
        io.sw_raw    = 10'h0;
        tick(DB + 6);
        check("idle_keys", 32'(io.pushbuttons_export), 32'h0);
        check("idle_sw", 32'(io.switches_export), 32'h0);
        check("idle_ecap", 32'(io.edge_capture), 32'h0);

        // 2. Bounce rejection on key 0
        seen_level = 1'b0;
        seen_press = 1'b0;
        for (int k = 0; k < 11 + DB + 6; k++) begin
            io.key_n_raw[0] = (k < 5) ? 1'b0 : (k == 5) ? 1'b1 : (k < 11) ? 1'b0 : 1'b1;
            tick(1);
            seen_level |= io.pushbuttons_export[0];
            seen_press |= io.press_pulse[0];
        end
        check("bounce_level", 32'(seen_level), 32'h0);
        check("bounce_press", 32'(seen_press), 32'h0);

        // 3. Clean press and release on key 2
        io.key_n_raw[2] = 1'b0;
        tick(DB + 2);
        check("k2_press_e9", 32'(io.pushbuttons_export), 32'h0);
        tick(1);
        check("k2_press_e10", 32'(io.pushbuttons_export), 32'h4);
        check("k2_pulse_e10", 32'(io.press_pulse), 32'h0);
        tick(1);
        check("k2_pulse_e11", 32'(io.press_pulse), 32'h4);
        tick(1);
        check("k2_pulse_e12", 32'(io.press_pulse), 32'h0);
        tick(7);
        io.key_n_raw[2] = 1'b1;
        tick(DB + 2);
        check("k2_rel_e9", 32'(io.pushbuttons_export), 32'h4);
        tick(1);
        check("k2_rel_e10", 32'(io.pushbuttons_export), 32'h0);
        check("k2_relp_e10", 32'(io.release_pulse), 32'h0);
        tick(1);
        check("k2_relp_e11", 32'(io.release_pulse), 32'h4);
        check("k2_relp_nopress", 32'(io.press_pulse), 32'h0);
        tick(1);
        check("k2_relp_e12", 32'(io.release_pulse), 32'h0);
        check("k2_ecap", 32'(io.edge_capture), 32'h4);
        io.edge_clear = 4'hF;
        tick(1);
        io.edge_clear = 4'h0;

        // 4. Edge capture on key 1
        io.key_n_raw[1] = 1'b0;
        tick(DB + 5);
        io.key_n_raw[1] = 1'b1;
        tick(DB + 6);
        check("k1_ecap_after_rel", 32'(io.edge_capture), 32'h2);
        io.edge_clear = 4'b0010;
        tick(1);
        io.edge_clear = 4'b0000;
        check("k1_ecap_cleared", 32'(io.edge_capture), 32'h0);
        io.key_n_raw[1] = 1'b0;
        tick(DB + 4);                          // after edge 11
        check("k1_pulse2", 32'(io.press_pulse), 32'h2);
        io.edge_clear = 4'b0010;
        tick(1);
        io.edge_clear = 4'b0000;
        check("k1_set_wins", 32'(io.edge_capture), 32'h2);
        io.key_n_raw[1] = 1'b1;
        tick(DB + 6);

        // 5. Reset while switch 5 is mid-count
        io.sw_raw[5] = 1'b1;
        tick(7);                               // count is 5 after edge 6
        reset_reset = 1'b1;
        tick(1);
        reset_reset = 1'b0;
        check("sw5_reset_level", 32'(io.switches_export), 32'h0);
        check("sw5_reset_ecap", 32'(io.edge_capture), 32'h0);
        tick(DB + 2);
        check("sw5_e9", 32'(io.switches_export), 32'h0);
        tick(1);
        check("sw5_e10", 32'(io.switches_export), 32'h020);
        io.sw_raw[5] = 1'b0;
        tick(DB + 6);
        check("sw5_off", 32'(io.switches_export), 32'h0);

        // 6. All channels toggle together
        io.key_n_raw = 4'h0;
        io.sw_raw    = 10'h3FF;
        tick(DB + 2);
        check("all_keys_e9", 32'(io.pushbuttons_export), 32'h0);
        check("all_sw_e9", 32'(io.switches_export), 32'h0);
        tick(1);
        check("all_keys_e10", 32'(io.pushbuttons_export), 32'hF);
        check("all_sw_e10", 32'(io.switches_export), 32'h3FF);
        tick(1);
        check("all_press_e11", 32'(io.press_pulse), 32'hF);
        check("all_release_e11", 32'(io.release_pulse), 32'h0);
        tick(1);
        check("all_ecap", 32'(io.edge_capture), 32'hF);

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end
endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
Conditions the raw DE1-SoC pushbuttons and slide switches before they reach the HPS/Qsys system's pushbuttons and switches PIO inputs. Per channel it provides:
- a two-flop synchroniser
- a counter-based debouncer
- press and release event pulses
- a sticky per-key edge-capture register that software can clear

It sits directly upstream of pushbuttons_export[3:0] and switches_export[9:0].

Parameters:
- N_KEYS, 4, number of pushbutton channels
- N_SW, 10, number of slide-switch channels
- DEBOUNCE_CYCLES, 500000, stable cycles required before a level is accepted (10 ms at 50 MHz); minimum 2
- CNT_W, 20, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES

Ports:
- clk_clk  in  1  system clock (50 MHz)
- reset_reset  in  1  synchronous reset, active-high
- key_n_raw  in  N_KEYS  raw pushbutton pins, active-low, asynchronous
- sw_raw  in  N_SW  raw slide-switch pins, active-high, asynchronous
- pushbuttons_export  out  N_KEYS  debounced key level, 1 = pressed
- switches_export  out  N_SW  debounced switch level
- press_pulse  out  N_KEYS  one-cycle pulse on each accepted press
- release_pulse  out  N_KEYS  one-cycle pulse on each accepted release
- edge_capture  out  N_KEYS  sticky press flags
- edge_clear  in  N_KEYS  write-1-to-clear for edge_capture, sampled each cycle

Behaviour:
- Interface: one clock, clk_clk; reset_reset is synchronous and active-high. All state updates on the rising edge of clk_clk.
- Key inversion: keys are inverted at input (pressed = ~key_n_raw). From that point all channels are active-high and identical.
- Synchroniser: two flops per channel (s1, s2). Reset values:
  - key channels: 0 (not pressed)
  - switch channels: 0
- Per-channel debouncer: state is stable (1 bit) and cnt (CNT_W bits). Each cycle:
  - s2 == stable: cnt <= 0.
  - s2 != stable and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - s2 != stable and cnt == DEBOUNCE_CYCLES-1: stable <= s2, cnt <= 0.
- Glitch rejection: any return of s2 to stable before acceptance restarts the count from 0. No partial credit is kept.
- Latency: a clean step on a raw pin first sampled at edge 0 changes the stable output at edge 2 + DEBOUNCE_CYCLES.
- Outputs: pushbuttons_export = stable of key channels; switches_export = stable of switch channels. Both are registered and reset to 0.
- Switches at power-up: switches held high at reset are reported as 0 until one debounce period after reset deasserts. This is intended; software waits 20 ms.
- Event pulses:
  - press_pulse[i] = 1 for exactly the cycle after stable[i] goes 0->1.
  - release_pulse[i] = 1 for exactly the cycle after stable[i] goes 1->0.
  - Both are registered; reset 0; never asserted together.
- edge_capture[i]:
  - set on press_pulse[i]
  - cleared when edge_clear[i] = 1
  - set and clear in the same cycle: set wins, result 1
  - reset value 0
- Reset mid-count: all cnt, stable, s1, s2, pulses and edge_capture return to 0 on the next edge. No pulse is emitted due to reset.
- Counter overflow: impossible by the CNT_W constraint. Elaboration asserts 2^CNT_W > DEBOUNCE_CYCLES and DEBOUNCE_CYCLES >= 2.

Decomposition:
- Shared package input_cond_pkg holds:
  - DEFAULT_DEBOUNCE_CYCLES (500000)
  - SIM_DEBOUNCE_CYCLES (8)
  - CLK_HZ (50000000)
  - a function computing the minimum CNT_W from DEBOUNCE_CYCLES
- One natural sub-module: debounce_channel (synchroniser + counter + stable + rise/fall detect). Instantiated N_KEYS + N_SW times via generate.
- The top level adds key inversion and edge_capture.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=8, CNT_W=4.
1. Reset: hold reset_reset=1 for 3 cycles with key_n_raw=4'b0000 and sw_raw=10'h3FF -> all outputs 0 during reset. After release, pushbuttons_export=4'hF and switches_export=10'h3FF at exactly edge 10 after the first unreset edge.
2. Bounce rejection: key_n_raw[0] low 5 cycles, high 1, low 5, high -> pushbuttons_export[0] stays 0 and press_pulse never asserts.
3. Clean press/release: key_n_raw[2] 1->0 at edge 0, held 20 cycles, then 0->1 -> pushbuttons_export[2]=1 at edge 10 and press_pulse[2]=1 only at edge 11. On release, pushbuttons_export[2]=0 and release_pulse[2] fires 10 and 11 edges after the rising edge respectively.
4. Edge capture: press key 1 -> edge_capture=4'b0010 persists after release. Assert edge_clear=4'b0010 for one cycle -> 4'b0000. Then assert edge_clear[1] in the same cycle as press_pulse[1] -> edge_capture[1]=1.
5. Reset mid-count: hold sw_raw[5] high; assert reset_reset at debounce count 5 for 1 cycle -> cnt restarts. switches_export[5] rises 10 edges after reset deasserts, not earlier.
6. Simultaneous channels: toggle all 4 keys and 10 switches on the same edge -> all outputs update on the same cycle and 4 press_pulses fire together.
